// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush controller for the five pipeline registers, with
//            redirect replay across memory waits and a memory-wait watchdog.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
    parameter logic [31:0] EXC_OFFSET    = 32'h0000_0180,
    parameter logic [31:0] REFILL_OFFSET = 32'h0000_0000,
    parameter int          TIMEOUT       = 1023,
    parameter int          CNT_W         = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemReady,
    input  logic        IdPauseRequest,
    input  logic        ExPauseRequest,
    input  logic        ExcValid,
    input  logic        ExcRefill,
    input  logic        EretValid,
    input  logic [31:0] EBase,
    input  logic [31:0] EPC,
    output logic        PcReady,
    output logic        IfIdReady,
    output logic        IdExReady,
    output logic        ExMemReady,
    output logic        MemWbReady,
    output logic        IdExPause,
    output logic        ExMemPause,
    output logic        flush,
    output logic [31:0] flushTarget,
    output logic        FlushPending,
    output logic        BusTimeout
);

    localparam logic [0:0]       c_RUN   = 1'b0;
    localparam logic [0:0]       c_PEND  = 1'b1;
    localparam logic [CNT_W-1:0] c_TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TO_M1 = CNT_W'(TIMEOUT - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [31:0]      r_pend_target;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_to_fired;
    logic             w_req;
    logic [31:0]      w_target;
    logic             w_to_hit;
    logic             w_latch;

    assign w_req    = ExcValid | EretValid;
    assign w_target = ExcValid ? (EBase + (ExcRefill ? REFILL_OFFSET : EXC_OFFSET)) : EPC;
    // Only a redirect seen in RUN is captured; later ones during the same wait are dropped.
    assign w_latch  = !MemReady && (r_state == c_RUN) && w_req;
    assign w_to_hit = (TIMEOUT != 0) && !MemReady && !r_to_fired && (r_wait_cnt == c_TO_M1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!MemReady) begin
            if (w_latch) begin
                w_state_next = c_PEND;
            end
        end else if (r_state == c_PEND) begin
            w_state_next = c_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pend_target <= 32'd0;
            r_wait_cnt    <= '0;
            r_to_fired    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_pend_target <= w_target;
            end
            if (MemReady) begin
                r_wait_cnt <= '0;
                r_to_fired <= 1'b0;
            end else begin
                if (r_wait_cnt != c_TO) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (w_to_hit) begin
                    r_to_fired <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        PcReady      = 1'b1;
        IfIdReady    = 1'b1;
        IdExReady    = 1'b1;
        ExMemReady   = 1'b1;
        MemWbReady   = 1'b1;
        IdExPause    = 1'b0;
        ExMemPause   = 1'b0;
        flush        = 1'b0;
        flushTarget  = 32'd0;
        FlushPending = 1'b0;
        BusTimeout   = 1'b0;
        if (reset) begin
            FlushPending = (r_state == c_PEND);
            BusTimeout   = w_to_hit;
            if (!MemReady) begin
                PcReady    = 1'b0;
                IfIdReady  = 1'b0;
                IdExReady  = 1'b0;
                ExMemReady = 1'b0;
                MemWbReady = 1'b0;
            end else if (r_state == c_PEND) begin
                flush       = 1'b1;
                flushTarget = r_pend_target;
            end else if (w_req) begin
                flush       = 1'b1;
                flushTarget = w_target;
            end else if (ExPauseRequest) begin
                PcReady    = 1'b0;
                IfIdReady  = 1'b0;
                IdExReady  = 1'b0;
                ExMemPause = 1'b1;
            end else if (IdPauseRequest) begin
                PcReady   = 1'b0;
                IfIdReady = 1'b0;
                IdExPause = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
